// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction-fetch stage: bus widths, fetch FSM states,
// and the {pc, inst} pair that travels from IF to ID.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 16;
  localparam int unsigned INST_W      = 16;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  // Sequential PC step; wraps FFFF -> 0000 by construction.
  function automatic inst_addr_t next_seq_pc(inst_addr_t pc);
    return pc + inst_addr_t'(1);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory port: IF drives request/address, memory answers with
// ready/data after a variable number of wait states.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic       req;
  inst_addr_t addr;
  logic       ready;
  inst_t      data;

  modport master (output req, addr, input ready, data);
  modport slave  (input req, addr, output ready, data);

endinterface

// File: rtl/if_hold_buf.sv
// Single-entry {pc, inst} buffer that parks a completed fetch while ID stalls.
module if_hold_buf
  import if_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         valid
);

  fetch_entry_t entry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // NOTE: the payload has no reset; valid alone says whether it means anything.
  always_ff @(posedge clk) begin
    if (load) begin
      entry_q <= din;
    end
  end

  assign dout = entry_q;

endmodule

// File: rtl/if_fetch.sv
// IF stage: owns the PC, talks to instruction memory, and feeds ID with
// {pc_o, inst_o}, bubbling NOPs when nothing is ready.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 16'h0000,
  parameter inst_t      NOP_INST = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  inst_addr_t        branch_addr_i,
  input  logic              flush_i,
  input  inst_addr_t        flush_addr_i,
  if_fetch_if.master        imem,
  output inst_addr_t        pc_o,
  output inst_t             inst_o
);

  fetch_state_e state_q, state_d;
  inst_addr_t   pc_q, pc_d;
  inst_addr_t   pc_out_q, pc_out_d;
  inst_t        inst_out_q, inst_out_d;
  logic         redir_pend_q, redir_pend_d;
  inst_addr_t   redir_addr_q, redir_addr_d;
  inst_addr_t   seq_pc;
  logic         fetch_req;
  logic         buf_load, buf_drain, buf_clear, buf_valid;
  fetch_entry_t buf_din, buf_dout;

  assign buf_din = '{pc: pc_q, inst: imem.data};

  if_hold_buf u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .drain (buf_drain),
    .clear (buf_clear),
    .din   (buf_din),
    .dout  (buf_dout),
    .valid (buf_valid)
  );

  // A pending redirect replaces the sequential step once the delay slot lands.
  assign seq_pc = redir_pend_q ? redir_addr_q : next_seq_pc(pc_q);

  // NOTE: every output of this block gets a default first, so no latches form.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_out_d     = pc_out_q;
    inst_out_d   = inst_out_q;
    redir_pend_d = redir_pend_q;
    redir_addr_d = redir_addr_q;
    fetch_req    = 1'b0;
    buf_load     = 1'b0;
    buf_drain    = 1'b0;
    buf_clear    = 1'b0;

    if (flush_i) begin
      pc_d         = flush_addr_i;
      inst_out_d   = NOP_INST;
      buf_clear    = 1'b1;
      redir_pend_d = 1'b0;
      state_d      = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          fetch_req = 1'b1;
          if (imem.ready) begin
            redir_pend_d = 1'b0;
            if (stall_i) begin
              buf_load = 1'b1;
              pc_d     = seq_pc;
              state_d  = HOLD;
            end else begin
              pc_out_d   = pc_q;
              inst_out_d = imem.data;
              // The completing fetch is the delay slot, so redirect right away.
              pc_d       = branch_flag_i ? branch_addr_i : seq_pc;
            end
          end else if (!stall_i) begin
            inst_out_d = NOP_INST;
            if (branch_flag_i) begin
              redir_pend_d = 1'b1;
              redir_addr_d = branch_addr_i;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            buf_drain  = 1'b1;
            state_d    = FETCH;
            pc_out_d   = buf_valid ? buf_dout.pc   : pc_out_q;
            inst_out_d = buf_valid ? buf_dout.inst : NOP_INST;
            if (branch_flag_i) begin
              pc_d = branch_addr_i;
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pc_out_q     <= '0;
      inst_out_q   <= NOP_INST;
      redir_pend_q <= 1'b0;
      redir_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_out_q     <= pc_out_d;
      inst_out_q   <= inst_out_d;
      redir_pend_q <= redir_pend_d;
      redir_addr_q <= redir_addr_d;
    end
  end

  assign imem.req  = fetch_req & ~rst;
  assign imem.addr = pc_q;
  assign pc_o      = pc_out_q;
  assign inst_o    = inst_out_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a wait-state-programmable instruction memory.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam inst_t NOP = 16'h0800;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall_i;
  logic       branch_flag_i;
  inst_addr_t branch_addr_i;
  logic       flush_i;
  inst_addr_t flush_addr_i;
  inst_addr_t pc_o;
  inst_t      inst_o;

  int checks   = 0;
  int failures = 0;
  int waits    = 0;
  int wcnt     = 0;

  if_fetch_if imem ();

  if_fetch #(.RESET_PC(16'h0000), .NOP_INST(16'h0800)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .branch_flag_i (branch_flag_i),
    .branch_addr_i (branch_addr_i),
    .flush_i       (flush_i),
    .flush_addr_i  (flush_addr_i),
    .imem          (imem),
    .pc_o          (pc_o),
    .inst_o        (inst_o)
  );

  always #5 clk = ~clk;

  function automatic inst_t mem_val(inst_addr_t a);
    case (a)
      16'h0000: return 16'h4A0F;
      16'h0001: return 16'h4B01;
      16'h0002: return 16'h6801;
      default:  return {4'hC, a[11:0]};
    endcase
  endfunction

  // Memory answers after `waits` cycles of a held request.
  assign imem.ready = imem.req && (wcnt == waits);
  assign imem.data  = mem_val(imem.addr);

  always @(posedge clk) begin
    if (!imem.req || imem.ready) wcnt <= 0;
    else                         wcnt <= wcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(string tag, inst_addr_t exp_pc, inst_t exp_inst);
    check({tag, ".pc"}, pc_o, exp_pc);
    check({tag, ".inst"}, inst_o, exp_inst);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_addr_i = '0;
    flush_i = 1'b0; flush_addr_i = '0;

    // Reset
    tick();
    check_out("reset", 16'h0000, NOP);
    check("reset_req", {15'b0, imem.req}, 16'h0000);
    check("reset_addr", imem.addr, 16'h0000);
    rst = 1'b0; #1;
    check("req_after_reset", {15'b0, imem.req}, 16'h0001);

    // Zero-wait stream
    tick(); check_out("zw0", 16'h0000, 16'h4A0F); check("zw_addr1", imem.addr, 16'h0001);
    tick(); check_out("zw1", 16'h0001, 16'h4B01); check("zw_addr2", imem.addr, 16'h0002);
    tick(); check_out("zw2", 16'h0002, 16'h6801); check("zw_addr3", imem.addr, 16'h0003);
    tick(); check_out("zw3", 16'h0003, 16'hC003);

    // Two wait states: two bubbles, pc_o held
    waits = 2; #1;
    tick(); check_out("ws_bub0", 16'h0003, NOP); check("ws_addr_stable", imem.addr, 16'h0004);
    tick(); check_out("ws_bub1", 16'h0003, NOP);
    tick(); check_out("ws_data", 16'h0004, 16'hC004);

    // Branch at pc 5 coinciding with ready of the delay slot
    waits = 0; #1;
    tick(); check_out("br_pc5", 16'h0005, 16'hC005);
    branch_flag_i = 1'b1; branch_addr_i = 16'h0040; #1;
    tick(); branch_flag_i = 1'b0;
    check_out("br_slot", 16'h0006, 16'hC006);
    check("br_target_addr", imem.addr, 16'h0040);
    tick(); check_out("br_target", 16'h0040, 16'hC040);

    // Flush back to 5, then branch with a 2-wait delay-slot fetch
    flush_i = 1'b1; flush_addr_i = 16'h0005; #1;
    check("flush_req", {15'b0, imem.req}, 16'h0000);
    tick(); flush_i = 1'b0;
    check_out("flush5", 16'h0040, NOP);
    check("flush5_addr", imem.addr, 16'h0005);
    tick(); check_out("brw_pc5", 16'h0005, 16'hC005);
    waits = 2; branch_flag_i = 1'b1; branch_addr_i = 16'h0040; #1;
    tick(); branch_flag_i = 1'b0;
    check_out("brw_bub0", 16'h0005, NOP);
    check("brw_addr_hold", imem.addr, 16'h0006);
    tick(); check_out("brw_bub1", 16'h0005, NOP);
    tick(); check_out("brw_slot", 16'h0006, 16'hC006);
    check("brw_target_addr", imem.addr, 16'h0040);
    waits = 0; #1;
    tick(); check_out("brw_target", 16'h0040, 16'hC040);

    // Stall for 3 cycles while fetch of 0x41 completes
    stall_i = 1'b1; #1;
    tick(); check_out("hold0", 16'h0040, 16'hC040);
    check("hold_req", {15'b0, imem.req}, 16'h0000);
    check("hold_addr", imem.addr, 16'h0042);
    tick(); check_out("hold1", 16'h0040, 16'hC040);
    tick(); check_out("hold2", 16'h0040, 16'hC040);
    check("hold2_req", {15'b0, imem.req}, 16'h0000);
    stall_i = 1'b0; #1;
    tick(); check_out("release", 16'h0041, 16'hC041);
    check("release_req", {15'b0, imem.req}, 16'h0001);
    tick(); check_out("resume", 16'h0042, 16'hC042);

    // Flush with outstanding fetch and pending redirect
    waits = 2; branch_flag_i = 1'b1; branch_addr_i = 16'h0200; #1;
    tick(); branch_flag_i = 1'b0;
    check_out("fl_bub", 16'h0042, NOP);
    flush_i = 1'b1; flush_addr_i = 16'h0100; #1;
    tick(); flush_i = 1'b0;
    check_out("fl_nop", 16'h0042, NOP);
    check("fl_addr", imem.addr, 16'h0100);
    waits = 0; #1;
    tick(); check_out("fl_data", 16'h0100, 16'hC100);
    check("fl_redir_dropped", imem.addr, 16'h0101);

    // PC wrap
    flush_i = 1'b1; flush_addr_i = 16'hFFFF; #1;
    tick(); flush_i = 1'b0;
    tick(); check_out("wrap_ffff", 16'hFFFF, 16'hCFFF);
    check("wrap_addr", imem.addr, 16'h0000);
    tick(); check_out("wrap_0", 16'h0000, 16'h4A0F);
    tick(); check_out("wrap_1", 16'h0001, 16'h4B01);

    // Reset mid-wait
    waits = 2; #1;
    tick(); check_out("rw_bub", 16'h0001, NOP);
    check("rw_addr", imem.addr, 16'h0002);
    rst = 1'b1; #1;
    check("rw_req", {15'b0, imem.req}, 16'h0000);
    tick(); rst = 1'b0; waits = 0; #1;
    check_out("rw_reset", 16'h0000, NOP);
    check("rw_addr_reset", imem.addr, 16'h0000);
    tick(); check_out("rw_first", 16'h0000, 16'h4A0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
